// File: rtl/imm_decode_stage.sv
// Decode-stage front end: classifies the RV32 opcode into an immediate-format select and
// holds instruction/PC/select in a main register plus one skid entry. Optional: IMM_DECODE_ILLEGAL_EN.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] IN_INSTRUCTION,
  input  logic [XLEN-1:0] IN_PC,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_INSTRUCTION,
  output logic [XLEN-1:0] OUT_PC,
  output logic [2:0]      OUT_IMM_SELECT,
  output logic            OUT_ILLEGAL,
  output logic [15:0]     ILLEGAL_COUNT
);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      sel;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_ent;
  logic   in_ready_q, out_valid_q;
  logic   in_xfer, out_xfer;
  logic   ld_main_in, ld_main_skid, ld_skid;
  logic [2:0] in_sel;
`ifdef IMM_DECODE_ILLEGAL_EN
  logic        in_bad, main_bad_q, skid_bad_q;
  logic [15:0] cnt_q;
`endif

  always_comb begin
    in_sel = 3'b111;
`ifdef IMM_DECODE_ILLEGAL_EN
    in_bad = 1'b0;
`endif
    case (IN_INSTRUCTION[6:0])
      7'b0110111, 7'b0010111:                       in_sel = 3'b000;
      7'b1101111:                                   in_sel = 3'b001;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: in_sel = 3'b010;
      7'b1100011:                                   in_sel = 3'b011;
      7'b0100011:                                   in_sel = 3'b100;
      7'b0110011, 7'b0001111:                       in_sel = 3'b111;
      default: begin
`ifdef IMM_DECODE_ILLEGAL_EN
        in_bad = 1'b1;
`endif
      end
    endcase
  end

  assign in_ent   = '{instr: IN_INSTRUCTION, pc: IN_PC, sel: in_sel};
  assign in_xfer  = IN_VALID && in_ready_q;
  assign out_xfer = out_valid_q && OUT_READY;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      EMPTY: if (in_xfer) begin state_d = ONE; ld_main_in = 1'b1; end
      ONE: begin
        if (in_xfer && out_xfer) ld_main_in = 1'b1;
        else if (in_xfer) begin state_d = FULL; ld_skid = 1'b1; end
        else if (out_xfer) state_d = EMPTY;
      end
      FULL: if (out_xfer) begin state_d = ONE; ld_main_skid = 1'b1; end
      default: state_d = EMPTY;
    endcase
    // A same-cycle output still completes; only the held/incoming entries are dropped.
    if (FLUSH) begin
      state_d      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '{instr: '0, pc: '0, sel: 3'b111};
      skid_q      <= '{instr: '0, pc: '0, sel: 3'b111};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (ld_main_in)        main_q <= in_ent;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_ent;
    end
  end

`ifdef IMM_DECODE_ILLEGAL_EN
  // Counted at acceptance, so a later flush does not undo the count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      main_bad_q <= 1'b0;
      skid_bad_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (ld_main_in)        main_bad_q <= in_bad;
      else if (ld_main_skid) main_bad_q <= skid_bad_q;
      if (ld_skid)           skid_bad_q <= in_bad;
      if (in_xfer && in_bad && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end
  assign OUT_ILLEGAL   = main_bad_q;
  assign ILLEGAL_COUNT = cnt_q;
`else
  assign OUT_ILLEGAL   = 1'b0;
  assign ILLEGAL_COUNT = 16'd0;
`endif

  assign IN_READY        = in_ready_q;
  assign OUT_VALID       = out_valid_q;
  assign OUT_INSTRUCTION = main_q.instr;
  assign OUT_PC          = main_q.pc;
  assign OUT_IMM_SELECT  = main_q.sel;

endmodule
